// File: rtl/rgb_pwm_driver_pkg.sv
// Shared constants, the duty-triple type and the phase-wrap helper for rgb_pwm_driver.
package rgb_pkg;

   localparam int unsigned PWM_STEPS = 255;
   localparam logic [7:0]  PHASE_G   = 8'd85;
   localparam logic [7:0]  PHASE_B   = 8'd170;
   localparam logic [7:0]  CNT_MAX   = 8'(PWM_STEPS - 1);

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_duty_t;

   // (cnt + off) mod 255 using a 9-bit add and one conditional subtract.
   function automatic logic [7:0] wrap_phase(input logic [7:0] cnt, input logic [7:0] off);
      logic [8:0] sum;
      sum = {1'b0, cnt} + {1'b0, off};
      if (sum >= 9'(PWM_STEPS)) begin
         sum = sum - 9'(PWM_STEPS);
      end
      return sum[7:0];
   endfunction

endpackage

// File: rtl/rgb_pwm_driver_pwm_channel.sv
// One LED channel: phase-shifted compare of the shared counter against the duty,
// registered, then mapped to the pin polarity.
module pwm_channel
   import rgb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] cnt_i,
   input  logic [7:0] phase_i,
   input  logic [7:0] duty_i,
   input  logic       enable_i,
   input  logic       polarity_i,
   output logic       pin_o
);

   logic [7:0] phase;
   logic       on_d;
   logic       on_q;

   always_comb begin
      phase = wrap_phase(cnt_i, phase_i);
      on_d  = enable_i && (phase < duty_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         on_q <= 1'b0;
      end else begin
         on_q <= on_d;
      end
   end

   // Polarity is a static tie-off, so the XOR after the flop cannot glitch.
   assign pin_o = on_q ^ polarity_i;

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB PWM driver: prescaled 255-step counter, shadowed duty triple applied only
// at period boundaries, optional phase staggering of the green/blue channels.
module rgb_pwm_driver
   import rgb_pkg::*;
#(
   parameter int unsigned PRESCALE   = 47,
   parameter bit          STAGGER    = 1'b1,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_r,
   input  logic [7:0] in_g,
   input  logic [7:0] in_b,
   output logic       period_start,
   output logic       red_led,
   output logic       green_led,
   output logic       blue_led
);

   localparam int unsigned      PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]  PS_MAX = PS_W'(PRESCALE - 1);
   localparam logic [7:0]       OFF_G  = STAGGER ? PHASE_G : 8'd0;
   localparam logic [7:0]       OFF_B  = STAGGER ? PHASE_B : 8'd0;

   logic [PS_W-1:0] presc_q, presc_d;
   logic [7:0]      cnt_q, cnt_d;
   rgb_duty_t       active_q, active_d;
   rgb_duty_t       shadow_q, shadow_d;
   logic            pending_q, pending_d;
   logic            period_start_q, period_start_d;

   logic tick;
   logic boundary;
   logic accept;
   logic apply;

   // Handshake: a triple transfers on any clock where in_valid && in_ready;
   // in_ready is low exactly while the shadow holds an unapplied triple, and
   // the upstream stage keeps its data stable while in_valid && !in_ready.
   assign in_ready     = ~pending_q;
   assign period_start = period_start_q;

   always_comb begin
      tick     = enable && (presc_q == PS_MAX);
      boundary = tick && (cnt_q == CNT_MAX);
      accept   = in_valid && !pending_q;
      apply    = pending_q && (boundary || !enable);

      presc_d        = '0;
      cnt_d          = '0;
      active_d       = active_q;
      shadow_d       = shadow_q;
      pending_d      = pending_q;
      period_start_d = boundary;

      if (enable) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
         cnt_d   = cnt_q;
         if (tick) begin
            cnt_d = boundary ? 8'd0 : cnt_q + 8'd1;
         end
      end

      // apply needs pending_q=1 and accept needs pending_q=0, so they never collide.
      if (apply) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      if (accept) begin
         shadow_d  = {in_r, in_g, in_b};
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q        <= '0;
         cnt_q          <= '0;
         active_q       <= '0;
         shadow_q       <= '0;
         pending_q      <= 1'b0;
         period_start_q <= 1'b0;
      end else begin
         presc_q        <= presc_d;
         cnt_q          <= cnt_d;
         active_q       <= active_d;
         shadow_q       <= shadow_d;
         pending_q      <= pending_d;
         period_start_q <= period_start_d;
      end
   end

   pwm_channel u_red (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt_i      (cnt_q),
      .phase_i    (8'd0),
      .duty_i     (active_q.r),
      .enable_i   (enable),
      .polarity_i (ACTIVE_LOW),
      .pin_o      (red_led)
   );

   pwm_channel u_green (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt_i      (cnt_q),
      .phase_i    (OFF_G),
      .duty_i     (active_q.g),
      .enable_i   (enable),
      .polarity_i (ACTIVE_LOW),
      .pin_o      (green_led)
   );

   pwm_channel u_blue (
      .clk        (clk),
      .rst_n      (rst_n),
      .cnt_i      (cnt_q),
      .phase_i    (OFF_B),
      .duty_i     (active_q.b),
      .enable_i   (enable),
      .polarity_i (ACTIVE_LOW),
      .pin_o      (blue_led)
   );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: per-cycle scoreboard fed by an arithmetic reference
// model, plus directed per-period on-time measurements.
module tb_rgb_pwm_driver;

   localparam int unsigned P      = 2;
   localparam bit          STG    = 1'b1;
   localparam bit          AL     = 1'b1;
   localparam int unsigned PERIOD = P * 255;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_r = '0;
   logic [7:0] in_g = '0;
   logic [7:0] in_b = '0;
   logic       in_ready;
   logic       period_start;
   logic       red_led;
   logic       green_led;
   logic       blue_led;

   int total = 0;
   int bad   = 0;

   // Expected {period_start, red, green, blue, in_ready} after each clock edge.
   logic [4:0] exp_q[$];

   // Reference model state: enabled edges since last enable/reset, duties, shadow.
   int unsigned m_e;
   int          m_act[3];
   int          m_sh[3];
   bit          m_pend;

   rgb_pwm_driver #(
      .PRESCALE   (P),
      .STAGGER    (STG),
      .ACTIVE_LOW (AL)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_r         (in_r),
      .in_g         (in_g),
      .in_b         (in_b),
      .period_start (period_start),
      .red_led      (red_led),
      .green_led    (green_led),
      .blue_led     (blue_led)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_e    = 0;
      m_act  = '{0, 0, 0};
      m_sh   = '{0, 0, 0};
      m_pend = 1'b0;
   endtask

   // Plain-arithmetic view: the counter value is (enabled edges / P) mod 255 and
   // a period ends on every (255*P)-th enabled edge.
   task automatic model_step();
      int         cnt;
      int         ph;
      bit         bnd;
      logic [2:0] pins;
      int         in_d[3];
      cnt = int'((m_e / P) % 255);
      bnd = enable && (((m_e + 1) % PERIOD) == 0);
      for (int i = 0; i < 3; i++) begin
         ph = STG ? (cnt + 85 * i) % 255 : cnt;
         pins[2-i] = (enable && (ph < m_act[i])) ^ AL;
      end
      in_d = '{int'(in_r), int'(in_g), int'(in_b)};
      if (m_pend && (bnd || !enable)) begin
         m_act  = m_sh;
         m_pend = 1'b0;
      end else if (in_valid && !m_pend) begin
         m_sh   = in_d;
         m_pend = 1'b1;
      end
      m_e = enable ? m_e + 1 : 0;
      exp_q.push_back({bnd, pins, !m_pend});
   endtask

   // ---------------- scoreboard: model producer ----------------
   always @(posedge clk) begin
      if (!rst_n) begin
         model_reset();
         exp_q.push_back({1'b0, AL, AL, AL, 1'b1});
      end else begin
         model_step();
      end
   end

   always @(negedge rst_n) begin
      model_reset();
      exp_q.delete();
   end

   // ---------------- scoreboard: monitor ----------------
   always @(negedge clk) begin
      logic [4:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("period_start", int'(period_start), int'(e[4]));
         check("pins", int'({red_led, green_led, blue_led}), int'(e[3:1]));
         check("in_ready", int'(in_ready), int'(e[0]));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      logic rdy;
      bit   done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_r     = r;
      in_g     = g;
      in_b     = b;
      for (int k = 0; k < 4 * PERIOD && !done; k++) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         done = rdy;
      end
      if (!done) begin
         check("send_timeout", 0, 1);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_ps();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 2 * PERIOD + 10 && !seen; k++) begin
         @(negedge clk);
         seen = period_start;
      end
      if (!seen) begin
         check("period_start_timeout", 0, 1);
      end
   endtask

   // Counts on-cycles per channel over one full period; duty d must give d*P.
   task automatic measure(input string name, input bit sync, input int dr, input int dg,
                          input int db, input bit one_hot);
      int cr, cg, cb, c1, s;
      cr = 0; cg = 0; cb = 0; c1 = 0;
      if (sync) begin
         wait_ps();
      end
      for (int k = 0; k < PERIOD; k++) begin
         @(negedge clk);
         cr += int'(red_led ^ AL);
         cg += int'(green_led ^ AL);
         cb += int'(blue_led ^ AL);
         s = int'(red_led ^ AL) + int'(green_led ^ AL) + int'(blue_led ^ AL);
         if (s == 1) begin
            c1++;
         end
      end
      check({name, "_red_on"}, cr, dr * int'(P));
      check({name, "_green_on"}, cg, dg * int'(P));
      check({name, "_blue_on"}, cb, db * int'(P));
      if (one_hot) begin
         check({name, "_one_hot"}, c1, int'(PERIOD));
      end
      #1;
   endtask

   function automatic logic [7:0] rnd_duty();
      case ($urandom_range(0, 3))
         0:       return 8'd0;
         1:       return 8'd255;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      rst_n    = 1'b0;
      enable   = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      enable = 1'b1;

      // Idle: pins off, ready high, period_start every PERIOD clocks.
      measure("idle", 1'b1, 0, 0, 0, 1'b0);
      repeat (20) @(posedge clk);
      #1;

      // Mid-period transfer, applied at the next boundary.
      send(8'd128, 8'd0, 8'd255);
      check("ready_after_accept", int'(in_ready), 0);
      measure("first", 1'b1, 128, 0, 255, 1'b0);

      // Second triple held while the first is pending.
      repeat (30) @(posedge clk);
      #1;
      send(8'd200, 8'd50, 8'd7);
      send(8'd85, 8'd85, 8'd85);
      measure("stagger85", 1'b1, 85, 85, 85, STG);

      // Transfer in the boundary cycle: old duties last one more period.
      wait_ps();
      repeat (PERIOD - 1) @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_r = 8'd30; in_g = 8'd200; in_b = 8'd100;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      measure("bnd_old", 1'b1, 85, 85, 85, STG);
      measure("bnd_new", 1'b1, 30, 200, 100, 1'b0);

      // Pending triple loads while disabled; resume counts from cnt 0.
      send(8'd10, 8'd20, 8'd30);
      enable = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("ready_while_disabled", int'(in_ready), 1);
      enable = 1'b1;
      measure("resume", 1'b0, 10, 20, 30, 1'b0);

      // Asynchronous reset mid-period with a pending triple.
      send(8'd99, 8'd99, 8'd99);
      repeat (37) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_pins", int'({red_led, green_led, blue_led}), int'({AL, AL, AL}));
      check("rst_ready", int'(in_ready), 1);
      check("rst_period_start", int'(period_start), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      measure("after_rst", 1'b1, 0, 0, 0, 1'b0);

      // Randomized traffic with occasional enable drops.
      for (int n = 0; n < 24; n++) begin
         repeat ($urandom_range(1, 400)) @(posedge clk);
         #1;
         if ($urandom_range(0, 5) == 0) begin
            enable = 1'b0;
            repeat ($urandom_range(1, 20)) @(posedge clk);
            #1;
            enable = 1'b1;
         end
         send(rnd_duty(), rnd_duty(), rnd_duty());
      end

      repeat (PERIOD + 10) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
